// File: rtl/frenzy_input_pkg.sv
// Shared types and constants for the Frenzy input controller: coin FSM states,
// pad bit layout, joystick bit indices, PS/2 scan codes and small pad helpers.
package frenzy_input_pkg;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_e;

  // Field order matches the core's {fire, up, down, left, right} input bus.
  typedef struct packed {
    logic fire;
    logic up;
    logic down;
    logic left;
    logic right;
  } pad_t;

  localparam int unsigned JOY_RIGHT  = 0;
  localparam int unsigned JOY_LEFT   = 1;
  localparam int unsigned JOY_DOWN   = 2;
  localparam int unsigned JOY_UP     = 3;
  localparam int unsigned JOY_FIRE   = 4;
  localparam int unsigned JOY_START1 = 5;
  localparam int unsigned JOY_START2 = 6;
  localparam int unsigned JOY_COIN   = 7;

  localparam logic [7:0] SC_P1_UP     = 8'h75;
  localparam logic [7:0] SC_P1_DOWN   = 8'h72;
  localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
  localparam logic [7:0] SC_P1_FIRE_A = 8'h29;
  localparam logic [7:0] SC_P1_FIRE_B = 8'h14;
  localparam logic [7:0] SC_START1_A  = 8'h05;
  localparam logic [7:0] SC_START1_B  = 8'h16;
  localparam logic [7:0] SC_START2_A  = 8'h06;
  localparam logic [7:0] SC_START2_B  = 8'h1E;
  localparam logic [7:0] SC_COIN_A    = 8'h2E;
  localparam logic [7:0] SC_COIN_B    = 8'h36;
  localparam logic [7:0] SC_P2_UP     = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT   = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] SC_P2_FIRE   = 8'h1C;

  function automatic pad_t joy_to_pad(input logic [7:0] joy);
    pad_t p;
    p.fire  = joy[JOY_FIRE];
    p.up    = joy[JOY_UP];
    p.down  = joy[JOY_DOWN];
    p.left  = joy[JOY_LEFT];
    p.right = joy[JOY_RIGHT];
    return p;
  endfunction

  // The core misbehaves on impossible stick positions, so opposite pairs cancel.
  function automatic pad_t resolve_pad(input pad_t raw);
    pad_t r;
    r = raw;
    if (raw.up && raw.down) begin
      r.up   = 1'b0;
      r.down = 1'b0;
    end
    if (raw.left && raw.right) begin
      r.left  = 1'b0;
      r.right = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/frenzy_input_ctrl_if.sv
// Input bundle between the MiSTer framework (master) and the Frenzy input controller (slave).
interface frenzy_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [4:0]  p1;
  logic [4:0]  p2;
  logic        start1;
  logic        start2;
  logic        coin;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  p1, p2, start1, start2, coin
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output p1, p2, start1, start2, coin
  );
endinterface

// File: rtl/coin_pulse_gen.sv
// Turns coin-request rising edges into fixed-width coin pulses with a minimum gap;
// output rises one edge after the request edge, one extra edge is queued, the rest dropped.
module coin_pulse_gen
  import frenzy_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYCLES = 4000000,
  parameter int unsigned COIN_GAP_CYCLES   = 4000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req_i,
  output logic coin_o
);

  localparam int unsigned MAX_CYCLES =
    (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ? COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYCLES - 1);

  coin_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             req_q;
  logic             req_rise;

  assign req_rise = req_i & ~req_q;

  // req_q tracks the request even in reset so a held request never fires on release.
  always_ff @(posedge clk_sys) begin
    req_q <= req_i;
    if (reset) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      COIN_IDLE: begin
        if (req_rise) begin
          state_d = COIN_PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      COIN_PULSE: begin
        if (req_rise) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = COIN_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COIN_GAP: begin
        if (req_rise) pend_d = 1'b1;
        if (cnt_q == '0) begin
          if (pend_q || req_rise) begin
            state_d = COIN_PULSE;
            cnt_d   = PULSE_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = COIN_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = COIN_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign coin_o = (state_q == COIN_PULSE);

endmodule

// File: rtl/frenzy_input_ctrl.sv
// Merges PS/2 keyboard and two joypads into registered Frenzy player inputs plus a conditioned coin;
// joystick path 1 edge, keyboard path 2 edges, no backpressure.
module frenzy_input_ctrl
  import frenzy_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_CYCLES = 4000000,
  parameter int unsigned COIN_GAP_CYCLES   = 4000000
) (
  input  logic                clk_sys,
  input  logic                reset,
  frenzy_input_ctrl_if.slave  bus
);

  logic tog_q;
  logic key_evt;
  logic pressed;
  pad_t k1_q, k1_d, k2_q, k2_d;
  logic ks1_q, ks1_d, ks2_q, ks2_d, kcoin_q, kcoin_d;
  pad_t p1_q, p1_d, p2_q, p2_d;
  logic start1_q, start1_d, start2_q, start2_d;
  logic coin_req;
  logic unused_bits;

  assign key_evt = bus.ps2_key[10] ^ tog_q;
  assign pressed = bus.ps2_key[9];

  // Extended-key flag is deliberately ignored so arrow and keypad keys alias.
  assign unused_bits = ^{bus.ps2_key[8], bus.joystick_0[15:8], bus.joystick_1[15:8]};

  always_comb begin
    k1_d    = k1_q;
    k2_d    = k2_q;
    ks1_d   = ks1_q;
    ks2_d   = ks2_q;
    kcoin_d = kcoin_q;
    if (key_evt) begin
      case (bus.ps2_key[7:0])
        SC_P1_UP:                   k1_d.up    = pressed;
        SC_P1_DOWN:                 k1_d.down  = pressed;
        SC_P1_LEFT:                 k1_d.left  = pressed;
        SC_P1_RIGHT:                k1_d.right = pressed;
        SC_P1_FIRE_A, SC_P1_FIRE_B: k1_d.fire  = pressed;
        SC_START1_A, SC_START1_B:   ks1_d      = pressed;
        SC_START2_A, SC_START2_B:   ks2_d      = pressed;
        SC_COIN_A, SC_COIN_B:       kcoin_d    = pressed;
        SC_P2_UP:                   k2_d.up    = pressed;
        SC_P2_DOWN:                 k2_d.down  = pressed;
        SC_P2_LEFT:                 k2_d.left  = pressed;
        SC_P2_RIGHT:                k2_d.right = pressed;
        SC_P2_FIRE:                 k2_d.fire  = pressed;
        default: ;
      endcase
    end
  end

  always_comb begin
    p1_d     = resolve_pad(k1_q | joy_to_pad(bus.joystick_0[7:0]));
    p2_d     = resolve_pad(k2_q | joy_to_pad(bus.joystick_1[7:0]));
    start1_d = ks1_q | bus.joystick_0[JOY_START1] | bus.joystick_1[JOY_START1];
    start2_d = ks2_q | bus.joystick_0[JOY_START2] | bus.joystick_1[JOY_START2];
    coin_req = kcoin_q | bus.joystick_0[JOY_COIN] | bus.joystick_1[JOY_COIN];
  end

  // Toggle copy follows the key bus during reset so release never looks like an event.
  always_ff @(posedge clk_sys) begin
    tog_q <= bus.ps2_key[10];
    if (reset) begin
      k1_q     <= '0;
      k2_q     <= '0;
      ks1_q    <= 1'b0;
      ks2_q    <= 1'b0;
      kcoin_q  <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
    end else begin
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      ks1_q    <= ks1_d;
      ks2_q    <= ks2_d;
      kcoin_q  <= kcoin_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
    end
  end

  coin_pulse_gen #(
    .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
    .COIN_GAP_CYCLES   (COIN_GAP_CYCLES)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_i   (coin_req),
    .coin_o  (bus.coin)
  );

  assign bus.p1     = p1_q;
  assign bus.p2     = p2_q;
  assign bus.start1 = start1_q;
  assign bus.start2 = start2_q;

endmodule

// File: tb/tb_frenzy_input_ctrl.sv
// Scoreboard bench for frenzy_input_ctrl with a short coin pulse (4) and gap (3).
module tb_frenzy_input_ctrl;

  typedef enum int {SEL_P1, SEL_P2, SEL_S1, SEL_S2, SEL_COIN} sel_e;

  typedef struct {
    int          due;
    sel_e        sel;
    logic [4:0]  val;
    string       tag;
  } sb_t;

  logic clk_sys;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic tog;
  sb_t  sb[$];

  frenzy_input_ctrl_if bus ();

  frenzy_input_ctrl #(
    .COIN_PULSE_CYCLES (4),
    .COIN_GAP_CYCLES   (3)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_at(input sel_e sel, input int due, input logic [4:0] val, input string tag);
    sb_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic [4:0] observe(input sel_e sel);
    case (sel)
      SEL_P1:   return bus.p1;
      SEL_P2:   return bus.p2;
      SEL_S1:   return {4'd0, bus.start1};
      SEL_S2:   return {4'd0, bus.start2};
      default:  return {4'd0, bus.coin};
    endcase
  endfunction

  // Outputs settle after posedge; compare everything due this cycle on the falling edge.
  always @(negedge clk_sys) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_val(sb[i].tag, {27'd0, observe(sb[i].sel)}, {27'd0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic key_case(input logic [7:0] code, input logic ext, input sel_e sel,
                          input logic [4:0] val, input string tag);
    int k;
    k = cyc;
    send_key(1'b1, ext, code);
    expect_at(sel, k + 1, 5'd0, {tag, "_pre"});
    expect_at(sel, k + 2, val, {tag, "_press"});
    tick(3);
    k = cyc;
    send_key(1'b0, ext, code);
    expect_at(sel, k + 1, val, {tag, "_hold"});
    expect_at(sel, k + 2, 5'd0, {tag, "_release"});
    tick(3);
  endtask

  initial begin
    int k;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    tog    = 1'b1;
    // Toggle bit high and a mapped press on the bus while in reset: must not register.
    bus.ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
    bus.joystick_0 = 16'h0000;
    bus.joystick_1 = 16'h0000;

    tick(3);
    expect_at(SEL_P1, cyc, 5'd0, "rst_p1");
    expect_at(SEL_P2, cyc, 5'd0, "rst_p2");
    expect_at(SEL_S1, cyc, 5'd0, "rst_s1");
    expect_at(SEL_S2, cyc, 5'd0, "rst_s2");
    expect_at(SEL_COIN, cyc, 5'd0, "rst_coin");
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) expect_at(SEL_P1, cyc + i, 5'd0, "rel_no_event");
    tick(4);

    k = cyc;
    send_key(1'b1, 1'b0, 8'h1A);
    for (int i = 1; i <= 3; i++) begin
      expect_at(SEL_P1, k + i, 5'd0, "unmapped_p1");
      expect_at(SEL_P2, k + i, 5'd0, "unmapped_p2");
      expect_at(SEL_S1, k + i, 5'd0, "unmapped_s1");
      expect_at(SEL_S2, k + i, 5'd0, "unmapped_s2");
      expect_at(SEL_COIN, k + i, 5'd0, "unmapped_coin");
    end
    tick(4);

    // Up key held for 10 cycles.
    k = cyc;
    send_key(1'b1, 1'b0, 8'h75);
    for (int i = 0; i <= 13; i++)
      expect_at(SEL_P1, k + i, (i >= 2 && i <= 11) ? 5'b01000 : 5'b00000, "key_up_window");
    tick(10);
    send_key(1'b0, 1'b0, 8'h75);
    tick(5);

    key_case(8'h29, 1'b0, SEL_P1, 5'b10000, "k_p1_fire");
    key_case(8'h6B, 1'b1, SEL_P1, 5'b00010, "k_p1_left_ext");
    key_case(8'h74, 1'b0, SEL_P1, 5'b00001, "k_p1_right");
    key_case(8'h72, 1'b0, SEL_P1, 5'b00100, "k_p1_down");
    key_case(8'h2D, 1'b0, SEL_P2, 5'b01000, "k_p2_up");
    key_case(8'h23, 1'b0, SEL_P2, 5'b00010, "k_p2_left");
    key_case(8'h1C, 1'b0, SEL_P2, 5'b10000, "k_p2_fire");
    key_case(8'h16, 1'b0, SEL_S1, 5'b00001, "k_start1");
    key_case(8'h1E, 1'b0, SEL_S2, 5'b00001, "k_start2");

    k = cyc;
    bus.joystick_0 = 16'h000C;
    expect_at(SEL_P1, k + 1, 5'd0, "joy_ud_cancel");
    expect_at(SEL_P1, k + 2, 5'd0, "joy_ud_cancel2");
    tick(2);
    bus.joystick_0 = 16'h0008;
    expect_at(SEL_P1, k + 3, 5'b01000, "joy_up_after_release");
    tick(2);
    bus.joystick_0 = 16'h0000;
    bus.joystick_1 = 16'h0003;
    expect_at(SEL_P2, cyc + 1, 5'd0, "joy_lr_cancel");
    tick(2);
    bus.joystick_1 = 16'h0001;
    expect_at(SEL_P2, cyc + 1, 5'b00001, "joy_right_after_release");
    tick(2);
    bus.joystick_1 = 16'h0000;
    expect_at(SEL_P2, cyc + 1, 5'd0, "joy_p2_idle");
    tick(2);

    // Key up latched plus joystick down: the pair cancels across sources.
    k = cyc;
    send_key(1'b1, 1'b0, 8'h75);
    expect_at(SEL_P1, k + 2, 5'b01000, "mix_key_up");
    tick(3);
    bus.joystick_0 = 16'h0004;
    expect_at(SEL_P1, k + 4, 5'd0, "mix_cancel");
    tick(2);
    bus.joystick_0 = 16'h0000;
    expect_at(SEL_P1, k + 6, 5'b01000, "mix_up_back");
    tick(1);
    send_key(1'b0, 1'b0, 8'h75);
    expect_at(SEL_P1, k + 8, 5'd0, "mix_release");
    tick(3);

    bus.joystick_1 = 16'h0020;
    expect_at(SEL_S1, cyc + 1, 5'b00001, "joy1_start1");
    expect_at(SEL_S2, cyc + 1, 5'd0, "joy1_start2_off");
    tick(2);
    bus.joystick_1 = 16'h0000;
    bus.joystick_0 = 16'h0050;
    expect_at(SEL_S1, cyc + 1, 5'd0, "joy0_start1_off");
    expect_at(SEL_S2, cyc + 1, 5'b00001, "joy0_start2");
    expect_at(SEL_P1, cyc + 1, 5'b10000, "joy0_fire");
    tick(2);
    bus.joystick_0 = 16'h0000;
    expect_at(SEL_S2, cyc + 1, 5'd0, "joy0_start2_rel");
    tick(2);

    // Single-cycle coin on pad 2: 4 high then at least 3 low.
    k = cyc;
    bus.joystick_1 = 16'h0080;
    for (int i = 0; i <= 7; i++)
      expect_at(SEL_COIN, k + i, (i >= 1 && i <= 4) ? 5'd1 : 5'd0, "coin_single");
    tick(1);
    bus.joystick_1 = 16'h0000;
    tick(8);

    // Three edges two cycles apart: second queued, third dropped.
    k = cyc;
    for (int i = 0; i <= 17; i++)
      expect_at(SEL_COIN, k + i,
                ((i >= 1 && i <= 4) || (i >= 8 && i <= 11)) ? 5'd1 : 5'd0, "coin_triple");
    for (int j = 0; j < 6; j++) begin
      bus.joystick_0 = (j % 2 == 0) ? 16'h0080 : 16'h0000;
      tick(1);
    end
    tick(13);

    // Reset mid-pulse with a queued coin, request held through release.
    k = cyc;
    for (int i = 0; i <= 14; i++)
      expect_at(SEL_COIN, k + i, (i >= 1 && i <= 3) ? 5'd1 : 5'd0, "coin_reset_mid");
    bus.joystick_0 = 16'h0080;
    tick(1);
    bus.joystick_0 = 16'h0000;
    tick(1);
    bus.joystick_0 = 16'h0080;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    bus.joystick_0 = 16'h0000;
    tick(2);

    // Coin key: two-edge latency into the pulse generator.
    k = cyc;
    for (int i = 0; i <= 8; i++)
      expect_at(SEL_COIN, k + i, (i >= 2 && i <= 5) ? 5'd1 : 5'd0, "coin_key");
    send_key(1'b1, 1'b0, 8'h2E);
    tick(2);
    send_key(1'b0, 1'b0, 8'h2E);
    tick(10);

    check_val("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
